pb_gesture_decoder: RTL and testbench
=====================================

Name: pb_gesture_decoder

Overview:
Consumer end of the debounced push-button interface. Takes the debouncer's synchronous PB_state level and its PB_down/PB_up one-cycle strobes, and classifies each user gesture into one-cycle command pulses: short press, double click, long press, and auto-repeat while held. The laser controller's mode/intensity logic uses these pulses in place of raw button events. Single clock domain, same clock as the debouncer.

Parameters:
LONG_CYCLES, 25_000_000, cycles a press must be held before it counts as a long press (>=2).
DCLICK_CYCLES, 6_000_000, maximum release-to-second-press gap for a double click (>=2).
REPEAT_CYCLES, 5_000_000, period of repeat pulses during a long hold (>=2).
CNT_W, 25, timer width; must satisfy 2^CNT_W > max(LONG_CYCLES, DCLICK_CYCLES, REPEAT_CYCLES).

Ports:
clk  input  1  system clock, shared with the debouncer.
rst_n  input  1  asynchronous active-low reset.
PB_state  input  1  debounced button level, 1 = pressed.
PB_down  input  1  one-cycle strobe on a debounced press.
PB_up  input  1  one-cycle strobe on a debounced release.
short_press  output  1  one-cycle pulse for a single short press.
double_click  output  1  one-cycle pulse for a completed double click.
long_press  output  1  one-cycle pulse when the long-press threshold is reached.
repeat_pulse  output  1  one-cycle pulse every REPEAT_CYCLES while a long hold continues.
hold_active  output  1  level; 1 while in LONG_HELD.

Behaviour:
- Reset: asynchronous, active low. State = IDLE, timer = 0, all outputs 0. Reset asserted mid-gesture discards the gesture; no pulse is emitted.
- All outputs are registered. A pulse is high in the cycle after the edge at which the decision is made, and lasts exactly 1 cycle.
- Timer: loaded to 0 on every state entry; increments by 1 each cycle in a timed state; never wraps (saturates at all-ones).
- IDLE: PB_down -> PRESS1. A PB_state=1 level without a PB_down strobe (for example, button held through reset) is ignored until release and a fresh PB_down arrives.
- PRESS1:
  - PB_up with timer < LONG_CYCLES-1 -> WAIT2.
  - timer == LONG_CYCLES-1 with no PB_up -> long_press, then -> LONG_HELD.
  - long_press is therefore high in cycle t+LONG_CYCLES+1, where t is the cycle PB_down is sampled.
- WAIT2:
  - PB_down with timer < DCLICK_CYCLES-1 -> PRESS2.
  - timer == DCLICK_CYCLES-1 -> short_press, then -> IDLE.
  - A short press is reported only after the double-click window expires.
- PRESS2:
  - PB_up -> double_click, then -> IDLE.
  - timer == LONG_CYCLES-1 with no PB_up -> long_press, then -> LONG_HELD; no double_click is emitted.
- LONG_HELD:
  - hold_active = 1.
  - repeat_pulse fires each time timer == REPEAT_CYCLES-1; timer reloads to 0 on that cycle. The first repeat comes REPEAT_CYCLES after long_press.
  - PB_up -> IDLE; hold_active clears in the next cycle. No release pulse is emitted.
- Simultaneous PB_down and PB_up in the same cycle is a protocol violation: both are ignored and state and timer advance as if neither had occurred.
- Threshold cycle coinciding with an event: PB_up on the same cycle as timer == LONG_CYCLES-1 in PRESS1/PRESS2, or PB_down on the same cycle as timer == DCLICK_CYCLES-1 in WAIT2, gives the event priority (release or second press wins).
- Consistency recovery: PB_state=0 while in PRESS1, PRESS2 or LONG_HELD without a PB_up strobe -> return to IDLE silently.
- At most one of short_press, double_click, long_press, repeat_pulse is high in any cycle.

Decomposition:
- Shared package pb_gesture_pkg holds:
  - state enum: IDLE, PRESS1, WAIT2, PRESS2, LONG_HELD.
  - default threshold constants, so bench and top level agree.
- One sub-module: gesture_timer, a clear/enable saturating CNT_W counter with a registered compare-equal flag for a runtime-selected threshold. The FSM stays in pb_gesture_decoder.

Test Plan:
Bench parameters: LONG_CYCLES=100, DCLICK_CYCLES=40, REPEAT_CYCLES=20. Strobes driven consistently with PB_state.
1. Single click: PB_down at cycle 0, PB_up at cycle 10 -> short_press high only at cycle 11+40=51; no other pulses.
2. Double click: down at 0, up at 10, down at 30, up at 45 -> double_click high at cycle 46; short_press never asserted.
3. Long hold: down at 0, held 200 cycles -> long_press at cycle 101; hold_active 1 from 101; repeat_pulse at 121, 141, 161, 181; release at 200 -> hold_active 0 at 201.
4. Boundary: release exactly at timer == LONG_CYCLES-1 -> no long_press; short_press follows after the window. Second press exactly at timer == DCLICK_CYCLES-1 -> enters PRESS2, no short_press.
5. Robustness: PB_down and PB_up in the same cycle in IDLE -> no state change. Reset pulsed mid-PRESS1 -> all outputs 0 and no pulse afterward. Button held through reset release -> nothing until release and a new PB_down.
6. PB_state dropping in LONG_HELD without PB_up -> IDLE next cycle, hold_active 0, no pulses.

Source files
------------

// File: rtl/pb_gesture_pkg.sv
// Shared types and default thresholds for the push-button gesture decoder.
// Top level and bench both pull their defaults from here.
package pb_gesture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG_HELD
    } state_t;

    localparam int LONG_CYCLES_DEF   = 25_000_000;
    localparam int DCLICK_CYCLES_DEF = 6_000_000;
    localparam int REPEAT_CYCLES_DEF = 5_000_000;
    localparam int CNT_W_DEF         = 25;

endpackage

// File: rtl/pb_gesture_decoder_timer.sv
// Saturating up-counter with clear/enable and a registered equal flag.
// The flag is computed from the next count, so it is aligned with the count it describes.
module gesture_timer #(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_thr,
    output logic             o_hit
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             r_hit;

    always_comb begin
        w_count_next = r_count;
        if (i_clear) begin
            w_count_next = '0;
        end else if (i_enable && (r_count != '1)) begin
            w_count_next = r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_hit   <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_hit   <= (w_count_next == i_thr);
        end
    end

    assign o_hit = r_hit;

endmodule

// File: rtl/pb_gesture_decoder.sv
// Classifies debounced button activity into short/double/long/repeat command pulses.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | no gesture in progress; held level without a press strobe is ignored
//   PRESS1    | first press held, timing towards the long-press threshold
//   WAIT2     | released after a short press, timing the double-click window
//   PRESS2    | second press held; release completes a double click
//   LONG_HELD | long press reached, emitting periodic repeat pulses
module pb_gesture_decoder
    import pb_gesture_pkg::*;
#(
    parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int DCLICK_CYCLES = DCLICK_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic PB_state,
    input  logic PB_down,
    input  logic PB_up,
    output logic short_press,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic hold_active
);

    localparam logic [CNT_W-1:0] LONG_THR   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DCLICK_THR = CNT_W'(DCLICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_THR = CNT_W'(REPEAT_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_dn;
    logic             w_up;
    logic             w_hit;
    logic             w_clear;
    logic             w_enable;
    logic [CNT_W-1:0] w_thr;
    logic             w_short;
    logic             w_double;
    logic             w_long;
    logic             w_repeat;
    logic             r_short;
    logic             r_double;
    logic             r_long;
    logic             r_repeat;
    logic             r_hold;

    // Coincident strobes are a protocol violation and cancel each other.
    assign w_dn = PB_down & ~PB_up;
    assign w_up = PB_up & ~PB_down;

    always_comb begin
        w_state_next = r_state;
        w_short      = 1'b0;
        w_double     = 1'b0;
        w_long       = 1'b0;
        w_repeat     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_dn) w_state_next = PRESS1;
            end
            PRESS1: begin
                if (w_up) begin
                    w_state_next = WAIT2;
                end else if (!PB_state) begin
                    w_state_next = IDLE;
                end else if (w_hit) begin
                    w_long       = 1'b1;
                    w_state_next = LONG_HELD;
                end
            end
            WAIT2: begin
                if (w_dn) begin
                    w_state_next = PRESS2;
                end else if (w_hit) begin
                    w_short      = 1'b1;
                    w_state_next = IDLE;
                end
            end
            PRESS2: begin
                if (w_up) begin
                    w_double     = 1'b1;
                    w_state_next = IDLE;
                end else if (!PB_state) begin
                    w_state_next = IDLE;
                end else if (w_hit) begin
                    w_long       = 1'b1;
                    w_state_next = LONG_HELD;
                end
            end
            LONG_HELD: begin
                if (w_up || !PB_state) begin
                    w_state_next = IDLE;
                end else if (w_hit) begin
                    w_repeat = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Threshold follows the state the timer will be counting in next cycle.
    always_comb begin
        w_thr = '1;
        case (w_state_next)
            PRESS1, PRESS2: w_thr = LONG_THR;
            WAIT2:          w_thr = DCLICK_THR;
            LONG_HELD:      w_thr = REPEAT_THR;
            default:        w_thr = '1;
        endcase
    end

    assign w_clear  = (w_state_next != r_state) || w_repeat || (w_state_next == IDLE);
    assign w_enable = (w_state_next != IDLE);

    gesture_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_clear),
        .i_enable (w_enable),
        .i_thr    (w_thr),
        .o_hit    (w_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_short  <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
            r_hold   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_short  <= w_short;
            r_double <= w_double;
            r_long   <= w_long;
            r_repeat <= w_repeat;
            r_hold   <= (w_state_next == LONG_HELD);
        end
    end

    assign short_press  = r_short;
    assign double_click = r_double;
    assign long_press   = r_long;
    assign repeat_pulse = r_repeat;
    assign hold_active  = r_hold;

endmodule

// File: tb/tb_pb_gesture_decoder.sv
// Bench for pb_gesture_decoder: timestamp-based gesture model checked every cycle,
// plus directed timing checks for the documented gesture scenarios.
module tb_pb_gesture_decoder;

    localparam int L = 100;
    localparam int D = 40;
    localparam int R = 20;
    localparam int W = 8;

    localparam int M_IDLE   = 0;
    localparam int M_FIRST  = 1;
    localparam int M_GAP    = 2;
    localparam int M_SECOND = 3;
    localparam int M_HOLD   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pb_state = 1'b0;
    logic pb_down = 1'b0;
    logic pb_up = 1'b0;
    logic short_press, double_click, long_press, repeat_pulse, hold_active;

    int total = 0;
    int bad = 0;

    // Model: phase plus absolute entry timestamps; bit order {hold, repeat, long, double, short}.
    int         ph = M_IDLE;
    int         t_ent = 0;
    int         t_long = 0;
    int         ncyc = 0;
    logic [4:0] exp_o = '0;

    // Per-scenario observation record, indexed by output bit.
    int scn_n = 0;
    int first_at[5];
    int last_at[5];
    int cnt[5];

    always #5 clk = ~clk;

    pb_gesture_decoder #(
        .LONG_CYCLES   (L),
        .DCLICK_CYCLES (D),
        .REPEAT_CYCLES (R),
        .CNT_W         (W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PB_state     (pb_state),
        .PB_down      (pb_down),
        .PB_up        (pb_up),
        .short_press  (short_press),
        .double_click (double_click),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .hold_active  (hold_active)
    );

    function automatic logic [4:0] outs();
        return {hold_active, repeat_pulse, long_press, double_click, short_press};
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (t=%0t)", tag, $signed(got), $signed(want), $time);
        end
    endtask

    task automatic model_reset();
        ph    = M_IDLE;
        exp_o = '0;
    endtask

    // Given inputs of cycle n, predict outputs of cycle n+1.
    task automatic model_step(input logic st, input logic dn, input logic up);
        int         n;
        int         k;
        logic       d;
        logic       u;
        logic [4:0] nx;
        n  = ncyc;
        k  = n - t_ent;
        d  = dn && !up;
        u  = up && !dn;
        nx = '0;
        if (ph == M_IDLE) begin
            if (d) begin ph = M_FIRST; t_ent = n + 1; end
        end else if (ph == M_FIRST || ph == M_SECOND) begin
            if (u) begin
                if (ph == M_FIRST) begin ph = M_GAP; t_ent = n + 1; end
                else begin nx[1] = 1'b1; ph = M_IDLE; end
            end else if (!st) begin
                ph = M_IDLE;
            end else if (k == L - 1) begin
                nx[2] = 1'b1; ph = M_HOLD; t_ent = n + 1; t_long = n + 1;
            end
        end else if (ph == M_GAP) begin
            if (d) begin ph = M_SECOND; t_ent = n + 1; end
            else if (k == D - 1) begin nx[0] = 1'b1; ph = M_IDLE; end
        end else begin
            if (u || !st) ph = M_IDLE;
            else if (((n + 1 - t_long) % R) == 0) nx[3] = 1'b1;
        end
        nx[4] = (ph == M_HOLD);
        exp_o = nx;
    endtask

    task automatic scn_start();
        scn_n = 0;
        for (int b = 0; b < 5; b++) begin
            first_at[b] = -1;
            last_at[b]  = -1;
            cnt[b]      = 0;
        end
    endtask

    task automatic tick(input logic st, input logic dn, input logic up);
        logic [4:0] o;
        @(negedge clk);
        o = outs();
        chk_eq("cycle_outs", 32'(o), 32'(exp_o));
        for (int b = 0; b < 5; b++) begin
            if (o[b]) begin
                cnt[b]++;
                last_at[b] = scn_n;
                if (first_at[b] < 0) first_at[b] = scn_n;
            end
        end
        pb_state = st;
        pb_down  = dn;
        pb_up    = up;
        if (!rst_n) model_reset();
        else model_step(st, dn, up);
        ncyc++;
        scn_n++;
    endtask

    // One or two presses with down/up strobes at the given scenario cycles.
    task automatic run_presses(input int d0, input int u0, input int d1, input int u1, input int len);
        scn_start();
        for (int n = 0; n < len; n++) begin
            logic st, dn, up;
            st = (n >= d0 && n < u0) || (d1 >= 0 && n >= d1 && n < u1);
            dn = (n == d0) || (d1 >= 0 && n == d1);
            up = (n == u0) || (d1 >= 0 && n == u1);
            tick(st, dn, up);
        end
    endtask

    function automatic int pulses();
        return cnt[0] + cnt[1] + cnt[2] + cnt[3];
    endfunction

    initial begin
        model_reset();
        scn_start();
        tick(1'b0, 1'b0, 1'b0);
        chk_eq("reset_outs", 32'(outs()), 32'd0);
        tick(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0);

        // single click
        run_presses(0, 10, -1, -1, 70);
        chk_eq("s1_short_at", first_at[0], 51);
        chk_eq("s1_short_cnt", cnt[0], 1);
        chk_eq("s1_others", cnt[1] + cnt[2] + cnt[3] + cnt[4], 0);

        // double click
        run_presses(0, 10, 30, 45, 80);
        chk_eq("s2_double_at", first_at[1], 46);
        chk_eq("s2_double_cnt", cnt[1], 1);
        chk_eq("s2_short_cnt", cnt[0], 0);

        // long hold with repeats
        run_presses(0, 200, -1, -1, 240);
        chk_eq("s3_long_at", first_at[2], 101);
        chk_eq("s3_long_cnt", cnt[2], 1);
        chk_eq("s3_hold_first", first_at[4], 101);
        chk_eq("s3_hold_last", last_at[4], 200);
        chk_eq("s3_rep_first", first_at[3], 121);
        chk_eq("s3_rep_last", last_at[3], 181);
        chk_eq("s3_rep_cnt", cnt[3], 4);
        chk_eq("s3_no_click", cnt[0] + cnt[1], 0);

        // release exactly at the long threshold
        run_presses(0, 100, -1, -1, 170);
        chk_eq("s4a_long_cnt", cnt[2], 0);
        chk_eq("s4a_short_at", first_at[0], 141);

        // second press exactly at the double-click threshold
        run_presses(0, 10, 50, 60, 100);
        chk_eq("s4b_double_at", first_at[1], 61);
        chk_eq("s4b_short_cnt", cnt[0], 0);

        // simultaneous strobes in IDLE, then a level held without a press strobe
        scn_start();
        tick(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 150; i++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 60; i++) tick(1'b0, 1'b0, 1'b0);
        chk_eq("s5a_pulses", pulses() + cnt[4], 0);

        // reset mid-PRESS1, button held through reset release
        scn_start();
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 49; i++) tick(1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1 chk_eq("s5b_rst_outs", 32'(outs()), 32'd0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 120; i++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 60; i++) tick(1'b0, 1'b0, 1'b0);
        chk_eq("s5b_pulses", pulses() + cnt[4], 0);
        run_presses(0, 10, -1, -1, 70);
        chk_eq("s5c_short_at", first_at[0], 51);

        // level drop in LONG_HELD without a release strobe
        scn_start();
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 130; i++) tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 70; i++) tick(1'b0, 1'b0, 1'b0);
        chk_eq("s6_long_at", first_at[2], 101);
        chk_eq("s6_rep_cnt", cnt[3], 1);
        chk_eq("s6_hold_last", last_at[4], 130);
        chk_eq("s6_click_cnt", cnt[0] + cnt[1], 0);

        // randomized gestures, biased towards the thresholds
        scn_start();
        for (int g = 0; g < 150; g++) begin
            int plen;
            int gap;
            int sel;
            sel  = int'($urandom_range(0, 9));
            plen = (sel < 3) ? int'($urandom_range(L - 2, L + 1)) : int'($urandom_range(1, 180));
            sel  = int'($urandom_range(0, 9));
            gap  = (sel < 3) ? int'($urandom_range(D - 3, D)) : int'($urandom_range(1, 60));
            if ($urandom_range(0, 9) == 0) tick(1'b0, 1'b1, 1'b1);
            tick(1'b1, 1'b1, 1'b0);
            for (int i = 1; i < plen; i++) tick(1'b1, 1'b0, 1'b0);
            if ($urandom_range(0, 7) == 0) tick(1'b0, 1'b0, 1'b0);
            else tick(1'b0, 1'b0, 1'b1);
            for (int i = 0; i < gap; i++) tick(1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 100; i++) tick(1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
